// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// Package: alu_pkg
// Purpose: Shared types and constants for the EX-stage ALU blocks.
//   serial_state_t : control states of the serial add/subtract core
//   FLAG_*         : bit positions of N, Z, C, V within the 4-bit flags vector
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/digit_adder.sv
// ----------------------------------------------------------------------------
// Module: digit_adder
// Purpose: Combinational DIGIT-bit ripple adder. One instance is shared by
//          all slices of the serial adder.
// Ports:
//   a    in  DIGIT  addend slice
//   b    in  DIGIT  addend slice
//   cin  in  1      carry in
//   sum  out DIGIT  sum slice
//   cout out 1      carry out of the slice
// ----------------------------------------------------------------------------
module digit_adder #(
    parameter int unsigned DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule : digit_adder

// File: rtl/alu_serial_adder.sv
// ----------------------------------------------------------------------------
// Module: alu_serial_adder
// Purpose: Multi-cycle add/subtract core for the EX-stage ALU. Sums operand A
//          and the pre-conditioned operand B plus carry-in DIGIT bits per
//          cycle, LSB first, then presents the N-bit result and NZCV flags.
// Ports:
//   clk     in   1   clock, rising edge
//   rst     in   1   synchronous, active-high reset
//   start   in   1   request; sampled only in IDLE or DONE
//   a       in   N   operand A
//   b       in   N   operand B (already inverted for subtraction)
//   cin     in   1   carry-in (1 for subtraction)
//   busy    out  1   high while the operation runs
//   done    out  1   one-cycle pulse when result/flags become valid
//   result  out  N   sum, held until the next done
//   flags   out  4   {N,Z,C,V}, held with result
// ----------------------------------------------------------------------------
module alu_serial_adder
    import alu_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned DIGIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int unsigned NS = N / DIGIT;
    localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

    generate
        if ((N % DIGIT) != 0 || DIGIT == 0) begin : g_bad_params
            $error("alu_serial_adder: N must be a non-zero multiple of DIGIT");
        end
    endgenerate

    serial_state_t    state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [N-1:0]     a_q;
    logic [N-1:0]     b_q;
    logic [N-1:0]     work_q;
    logic [N-1:0]     work_d;
    logic [N-1:0]     result_q;
    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic             busy_q;
    logic             done_q;

    logic [DIGIT-1:0] a_slice;
    logic [DIGIT-1:0] b_slice;
    logic [DIGIT-1:0] sum_slice;
    logic             slice_cout;
    logic             last_slice;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (sum_slice),
        .cout (slice_cout)
    );

    // Slice select and work-register update are written as unrolled muxes
    // over constant part-selects, equivalent to a [cnt*DIGIT +: DIGIT] index.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        work_d  = work_q;
        for (int unsigned i = 0; i < NS; i++) begin
            if (cnt_q == CW'(i)) begin
                a_slice                   = a_q[i*DIGIT +: DIGIT];
                b_slice                   = b_q[i*DIGIT +: DIGIT];
                work_d[i*DIGIT +: DIGIT]  = sum_slice;
            end
        end
    end

    assign last_slice = (cnt_q == CW'(NS - 1));

    // Flags only matter on the last slice, where work_d holds the full sum
    // and slice_cout is the carry out of the top slice.
    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_N] = work_d[N-1];
        flags_d[FLAG_Z] = (work_d == '0);
        flags_d[FLAG_C] = slice_cout;
        flags_d[FLAG_V] = (a_q[N-1] == b_q[N-1]) && (work_d[N-1] != a_q[N-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    work_q  <= work_d;
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        cnt_q    <= '0;
                        result_q <= work_d;
                        flags_q  <= flags_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule : alu_serial_adder

// File: tb/tb_alu_serial_adder.sv
// ----------------------------------------------------------------------------
// Testbench: tb_alu_serial_adder
// Purpose: Directed checks of the serial add/subtract core at N=32, DIGIT=8.
// ----------------------------------------------------------------------------
module tb_alu_serial_adder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    alu_serial_adder #(
        .N     (32),
        .DIGIT (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for done; cyc counts cycles since the start edge.
    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = 1;
        busy_n = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_n++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic cv, input logic [31:0] er, input logic [3:0] ef);
        int cyc;
        int busy_n;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: only latched copies may be used.
        a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = ~cv;
        wait_done(cyc, busy_n);
        check({tag, "_latency"}, 64'(cyc), 64'd5);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd4);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_result"}, 64'(result), 64'(er));
        check({tag, "_flags"}, 64'(flags), 64'(ef));
    endtask

    initial begin
        int cyc;
        int busy_n;
        int done_n;
        int hold_bad;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        rst = 1'b0;

        run_op("add_5_3",     32'd5,         32'd3,         1'b0, 32'd8,         4'b0000);
        run_op("sub_5_5",     32'd5,         32'hFFFF_FFFA, 1'b1, 32'd0,         4'b0110);
        run_op("ovf_pos",     32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 4'b1001);
        run_op("wrap",        32'hFFFF_FFFF, 32'd1,         1'b0, 32'd0,         4'b0110);
        run_op("sub_3_5",     32'd3,         32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFE, 4'b1000);
        run_op("carry_chain", 32'h00FF_FFFF, 32'd1,         1'b0, 32'h0100_0000, 4'b0000);

        // start during RUN is ignored
        @(negedge clk);
        a = 32'd1; b = 32'd1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, busy_n);
        cyc = cyc + 2;
        check("ignore_latency", 64'(cyc), 64'd5);
        check("ignore_result", 64'(result), 64'd2);
        check("ignore_flags", 64'(flags), 64'd0);

        // reset mid-operation discards the op
        @(negedge clk);
        a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_flags", 64'(flags), 64'd0);
        done_n = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("midrst_no_done", 64'(done_n), 64'd0);

        // back-to-back: second start accepted in the DONE cycle
        @(negedge clk);
        a = 32'd10; b = 32'd20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, busy_n);
        check("b2b_first_latency", 64'(cyc), 64'd5);
        check("b2b_first_result", 64'(result), 64'd30);
        a = 32'd100; b = 32'd23; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc      = 1;
        hold_bad = 0;
        while (!done && cyc < 20) begin
            if (result !== 32'd30) hold_bad++;
            @(negedge clk);
            cyc++;
        end
        check("b2b_hold_first", 64'(hold_bad), 64'd0);
        check("b2b_done_spacing", 64'(cyc), 64'd5);
        check("b2b_second_result", 64'(result), 64'd123);
        check("b2b_second_flags", 64'(flags), 64'd0);
        @(negedge clk);
        check("b2b_done_pulse", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_serial_adder
